pixel_write_combiner: RTL and testbench

PIXEL_WRITE_COMBINER -- requirements
Module: pixel_write_combiner

---
 rtl/pixel_write_combiner_pkg.sv | 30 +++
 rtl/pixel_write_combiner_addr_calc.sv | 19 +
 rtl/pixel_write_combiner.sv | 222 ++++++++++++++++++++++
 tb/tb_pixel_write_combiner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_combiner_pkg.sv
// Shared constants and types for the pixel write combiner: screen geometry,
// frame-buffer layout, idle timeout and FSM encoding.
package pixel_write_combiner_pkg;

  localparam int unsigned ScreenWidth  = 640;
  localparam int unsigned ScreenHeight = 480;
  localparam int unsigned WordsPerRow  = ScreenWidth / 4;
  localparam int unsigned BufferWords  = WordsPerRow * ScreenHeight;
  localparam int unsigned IdleTimeout  = 16;

  localparam int unsigned AddrW  = 18;
  localparam int unsigned DataW  = 16;
  localparam int unsigned LanesN = 4;
  localparam int unsigned IdleW  = 4;

  typedef enum logic [2:0] {
    StEmpty,
    StHold,
    StFlush,
    StDoneFlush,
    StSwapWait
  } state_e;

  // Places a 4-bit value into the nibble lane selected by the pixel's low x bits.
  function automatic logic [DataW-1:0] lane_nibble(input logic [1:0] lane,
                                                   input logic [3:0] val);
    return {12'b0, val} << {lane, 2'b00};
  endfunction

endpackage

// File: rtl/pixel_write_combiner_addr_calc.sv
// Combinational pixel-to-word address mapping within one frame buffer,
// plus the on-screen range check.
module pixel_addr_calc
  import pixel_write_combiner_pkg::*;
(
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  output logic [16:0] o_addr,
  output logic        o_in_range
);

  logic [16:0] w_row_base;

  // y*160 as y*128 + y*32
  assign w_row_base = {1'b0, i_y, 7'b0} + {3'b0, i_y, 5'b0};
  assign o_addr     = w_row_base + {9'b0, i_x[9:2]};
  assign o_in_range = (i_x < 10'(ScreenWidth)) && (i_y < 9'(ScreenHeight));

endmodule

// File: rtl/pixel_write_combiner.sv
// Merges rasterizer pixel writes into 4-pixel memory words and manages
// double-buffer swapping on vsync after the frame has been fully flushed.
module pixel_write_combiner
  import pixel_write_combiner_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_rd_en,
  input  logic [9:0]       i_frame_x,
  input  logic [8:0]       i_frame_y,
  input  logic [2:0]       i_px_color,
  input  logic             i_raster_done,
  input  logic             i_vsync,
  output logic             o_frame_ready,
  output logic             o_mem_req,
  output logic [AddrW-1:0] o_mem_addr,
  output logic [DataW-1:0] o_mem_wdata,
  output logic [LanesN-1:0] o_mem_be,
  input  logic             i_mem_ack,
  output logic             o_front_sel,
  output logic             o_swap_done
);

  state_e              r_state;
  logic                r_buf_valid;
  logic [AddrW-1:0]    r_buf_addr;
  logic [DataW-1:0]    r_buf_data;
  logic [LanesN-1:0]   r_buf_be;
  logic                r_stg_valid;
  logic [AddrW-1:0]    r_stg_addr;
  logic [DataW-1:0]    r_stg_data;
  logic [LanesN-1:0]   r_stg_be;
  logic [IdleW-1:0]    r_idle;
  logic                r_done_pend;
  logic                r_front_sel;
  logic                r_swap_done;
  logic                r_mem_req;
  logic [AddrW-1:0]    r_mem_addr;
  logic [DataW-1:0]    r_mem_wdata;
  logic [LanesN-1:0]   r_mem_be;

  logic [16:0]         w_row_addr;
  logic                w_in_range;
  logic [AddrW-1:0]    w_pix_addr;
  logic [1:0]          w_lane;
  logic [DataW-1:0]    w_lane_data;
  logic [DataW-1:0]    w_lane_mask;
  logic [LanesN-1:0]   w_lane_be;
  logic                w_accept;
  logic                w_pix_ok;
  logic                w_hit;
  logic                w_hold_merge;
  logic                w_hold_miss;
  logic                w_timeout;
  logic                w_done_now;
  logic [DataW-1:0]    w_issue_data;
  logic [LanesN-1:0]   w_issue_be;

  pixel_addr_calc u_addr_calc (
    .i_x        (i_frame_x),
    .i_y        (i_frame_y),
    .o_addr     (w_row_addr),
    .o_in_range (w_in_range)
  );

  // Pixels always land in the back buffer, which is the one not being scanned out.
  assign w_pix_addr   = {1'b0, w_row_addr} + (r_front_sel ? 18'd0 : 18'(BufferWords));
  assign w_lane       = i_frame_x[1:0];
  assign w_lane_data  = lane_nibble(w_lane, {1'b0, i_px_color});
  assign w_lane_mask  = lane_nibble(w_lane, 4'hF);
  assign w_lane_be    = 4'b0001 << w_lane;

  assign o_frame_ready = ~i_rst & ((r_state == StEmpty) | (r_state == StHold));
  assign w_accept      = i_frame_rd_en & o_frame_ready;
  assign w_pix_ok      = w_accept & w_in_range;
  assign w_hit         = r_buf_valid & (w_pix_addr == r_buf_addr);
  assign w_hold_merge  = w_pix_ok & w_hit;
  assign w_hold_miss   = w_pix_ok & ~w_hit;
  assign w_timeout     = ~w_pix_ok & (r_idle == IdleW'(IdleTimeout - 1));
  assign w_done_now    = r_done_pend | i_raster_done;

  // Word contents as they stand after this cycle's merge, if any.
  assign w_issue_data = w_hold_merge ? ((r_buf_data & ~w_lane_mask) | w_lane_data) : r_buf_data;
  assign w_issue_be   = w_hold_merge ? (r_buf_be | w_lane_be) : r_buf_be;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StEmpty;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_buf_be    <= '0;
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
      r_stg_be    <= '0;
      r_idle      <= '0;
      r_done_pend <= 1'b0;
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_swap_done <= 1'b0;
      unique case (r_state)
        StEmpty: begin
          r_idle <= '0;
          if (w_pix_ok) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= w_pix_addr;
            r_buf_data  <= w_lane_data;
            r_buf_be    <= w_lane_be;
            if (i_raster_done) begin
              r_state     <= StDoneFlush;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= w_pix_addr;
              r_mem_wdata <= w_lane_data;
              r_mem_be    <= w_lane_be;
            end else begin
              r_state <= StHold;
            end
          end else if (i_raster_done) begin
            r_state <= StSwapWait;
          end
        end

        StHold: begin
          if (w_hold_merge) begin
            r_buf_data <= w_issue_data;
            r_buf_be   <= w_issue_be;
            r_idle     <= '0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
          if (w_hold_miss) begin
            r_stg_valid <= 1'b1;
            r_stg_addr  <= w_pix_addr;
            r_stg_data  <= w_lane_data;
            r_stg_be    <= w_lane_be;
            r_done_pend <= i_raster_done;
            r_state     <= StFlush;
          end else if (i_raster_done) begin
            r_state <= StDoneFlush;
          end else if (w_issue_be == 4'hF || w_timeout) begin
            r_state <= StFlush;
          end
          if (w_hold_miss || i_raster_done || w_issue_be == 4'hF || w_timeout) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_buf_addr;
            r_mem_wdata <= w_issue_data;
            r_mem_be    <= w_issue_be;
          end
        end

        StFlush: begin
          if (i_raster_done) r_done_pend <= 1'b1;
          if (i_mem_ack) begin
            if (r_stg_valid) begin
              r_buf_addr  <= r_stg_addr;
              r_buf_data  <= r_stg_data;
              r_buf_be    <= r_stg_be;
              r_stg_valid <= 1'b0;
              r_idle      <= '0;
              if (w_done_now) begin
                r_state     <= StDoneFlush;
                r_done_pend <= 1'b0;
                r_mem_addr  <= r_stg_addr;
                r_mem_wdata <= r_stg_data;
                r_mem_be    <= r_stg_be;
              end else begin
                r_state     <= StHold;
                r_mem_req   <= 1'b0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
                r_mem_be    <= '0;
              end
            end else begin
              r_buf_valid <= 1'b0;
              r_done_pend <= 1'b0;
              r_mem_req   <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_mem_be    <= '0;
              r_state     <= w_done_now ? StSwapWait : StEmpty;
            end
          end
        end

        StDoneFlush: begin
          if (i_mem_ack) begin
            r_buf_valid <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_state     <= StSwapWait;
          end
        end

        StSwapWait: begin
          if (i_vsync) begin
            r_front_sel <= ~r_front_sel;
            r_swap_done <= 1'b1;
            r_state     <= StEmpty;
          end
        end

        default: r_state <= StEmpty;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_front_sel = r_front_sel;
  assign o_swap_done = r_swap_done;

endmodule

// File: tb/tb_pixel_write_combiner.sv
// Directed bench for pixel_write_combiner: table of single-pixel timeout
// writes plus hand-written sequences for merge, miss, done and swap paths.
module tb_pixel_write_combiner;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [9:0]  fx;
  logic [8:0]  fy;
  logic [2:0]  col;
  logic        rdone;
  logic        vsync;
  logic        ack;
  logic        fready;
  logic        mreq;
  logic [17:0] maddr;
  logic [15:0] mwdata;
  logic [3:0]  mbe;
  logic        front;
  logic        swapd;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int x;
    int y;
    int c;
    int addr;
    int wdata;
    int be;
  } vec_t;

  vec_t vecs[5];

  pixel_write_combiner dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_rd_en (rd_en),
    .i_frame_x     (fx),
    .i_frame_y     (fy),
    .i_px_color    (col),
    .i_raster_done (rdone),
    .i_vsync       (vsync),
    .o_frame_ready (fready),
    .o_mem_req     (mreq),
    .o_mem_addr    (maddr),
    .o_mem_wdata   (mwdata),
    .o_mem_be      (mbe),
    .i_mem_ack     (ack),
    .o_front_sel   (front),
    .o_swap_done   (swapd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic pix(input int x, input int y, input int c);
    rd_en = 1'b1;
    fx    = 10'(x);
    fy    = 9'(y);
    col   = 3'(c);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic chk_write(input string name, input int addr, input int wdata, input int be);
    chk({name, " req"}, {31'b0, mreq}, 1);
    chk({name, " addr"}, {14'b0, maddr}, addr);
    chk({name, " wdata"}, {16'b0, mwdata}, wdata);
    chk({name, " be"}, {28'b0, mbe}, be);
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({name, " req after ack"}, {31'b0, mreq}, 0);
    chk({name, " wdata idle"}, {16'b0, mwdata}, 0);
    chk({name, " be idle"}, {28'b0, mbe}, 0);
  endtask

  task automatic wait_req(input int max, output int cyc);
    cyc = 0;
    while (!mreq && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int seen;

    vecs[0] = '{639, 479, 7, 153599, 'h7000, 'h8};
    vecs[1] = '{4, 0, 5, 76801, 'h0005, 'h1};
    vecs[2] = '{6, 2, 1, 77121, 'h0100, 'h4};
    vecs[3] = '{100, 10, 0, 78425, 'h0000, 'h1};
    vecs[4] = '{323, 200, 6, 108880, 'h6000, 'h8};

    rst = 1'b1; rd_en = 1'b0; fx = '0; fy = '0; col = '0;
    rdone = 1'b0; vsync = 1'b0; ack = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst fready", {31'b0, fready}, 0);
    chk("rst mreq", {31'b0, mreq}, 0);
    chk("rst maddr", {14'b0, maddr}, 0);
    chk("rst front", {31'b0, front}, 0);
    chk("rst swapd", {31'b0, swapd}, 0);
    rst = 1'b0;
    tick();
    chk("post-rst fready", {31'b0, fready}, 1);

    // Four lanes of one word fill the buffer and flush immediately
    pix(0, 0, 1);
    pix(1, 0, 2);
    pix(2, 0, 3);
    pix(3, 0, 4);
    chk_write("full", 'h12C00, 'h4321, 'hF);
    chk("full fready", {31'b0, fready}, 0);
    tick();
    chk_write("full held", 'h12C00, 'h4321, 'hF);
    do_ack("full");
    chk("full fready after", {31'b0, fready}, 1);

    // Miss stages the new pixel; staged pixel becomes the buffer after ack
    pix(5, 1, 3);
    pix(9, 1, 2);
    chk_write("miss", 76961, 'h0030, 'h2);
    tick();
    chk("miss fready held low", {31'b0, fready}, 0);
    do_ack("miss");
    chk("miss fready hold", {31'b0, fready}, 1);
    wait_req(40, cyc);
    chk("staged timeout cycles", cyc, 16);
    chk_write("staged", 76962, 'h0020, 'h2);
    do_ack("staged");

    // Single pixels flushed by the idle timeout
    for (int i = 0; i < 5; i++) begin
      pix(vecs[i].x, vecs[i].y, vecs[i].c);
      chk($sformatf("vec%0d no early req", i), {31'b0, mreq}, 0);
      wait_req(40, cyc);
      chk($sformatf("vec%0d timeout cycles", i), cyc, 16);
      chk_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].be);
      do_ack($sformatf("vec%0d", i));
    end

    // Repeated lane is overwritten by the newest color
    pix(8, 3, 1);
    pix(8, 3, 5);
    pix(9, 3, 2);
    pix(10, 3, 3);
    pix(11, 3, 4);
    chk_write("overwrite", 77282, 'h4325, 'hF);
    do_ack("overwrite");

    // Off-screen pixels are dropped
    pix(640, 0, 1);
    pix(0, 480, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mreq) seen++;
      tick();
    end
    chk("offscreen no req", seen, 0);
    chk("offscreen fready", {31'b0, fready}, 1);

    // Partial buffer, raster_done, then swap on vsync
    pix(20, 4, 6);
    chk("done fready before", {31'b0, fready}, 1);
    rdone = 1'b1;
    tick();
    rdone = 1'b0;
    chk_write("done flush", 77445, 'h0006, 'h1);
    chk("done fready", {31'b0, fready}, 0);
    do_ack("done");
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (fready || swapd || front) seen++;
      tick();
    end
    chk("swap wait quiet", seen, 0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("swap front", {31'b0, front}, 1);
    chk("swap pulse", {31'b0, swapd}, 1);
    chk("swap fready", {31'b0, fready}, 1);
    tick();
    chk("swap pulse end", {31'b0, swapd}, 0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("vsync ignored front", {31'b0, front}, 1);
    chk("vsync ignored pulse", {31'b0, swapd}, 0);

    // Reset during FLUSH; front buffer is now 1 so writes target buffer 0
    pix(0, 0, 5);
    pix(1, 0, 6);
    pix(2, 0, 7);
    pix(3, 0, 1);
    chk_write("pre-rst", 0, 'h1765, 'hF);
    rst = 1'b1;
    tick();
    chk("rst flush mreq", {31'b0, mreq}, 0);
    chk("rst flush front", {31'b0, front}, 0);
    chk("rst flush wdata", {16'b0, mwdata}, 0);
    chk("rst flush fready", {31'b0, fready}, 0);
    rst = 1'b0;
    tick();
    chk("rst flush fready after", {31'b0, fready}, 1);

    // raster_done together with a miss: both words written, then swap
    pix(0, 0, 1);
    rdone = 1'b1;
    pix(4, 0, 2);
    rdone = 1'b0;
    chk_write("done miss 1st", 76800, 'h0001, 'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_write("done miss 2nd", 76801, 'h0002, 'h1);
    do_ack("done miss");
    chk("done miss fready", {31'b0, fready}, 0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("done miss front", {31'b0, front}, 1);
    chk("done miss pulse", {31'b0, swapd}, 1);
    tick();
    chk("done miss pulse end", {31'b0, swapd}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
